stp8to128: RTL and testbench
============================

// Module: stp8to128
// PURPOSE
//  Serial-to-parallel assembler: accepts 8-bit bytes over a valid/ready handshake and packs 16 of them
//  into one 128-bit block. Receive-side counterpart of the 128-to-8 byte serializer.
//  Sits between the byte-wide link and the 128-bit block datapath; the first byte received is the block's MSB byte.
// PARAMETERS
//  NUM_BITS   128  assembled block width; must be a multiple of NUM_IN
//  NUM_IN     8    input word width
//  SHIFT_MSB  1    1: first byte -> block[NUM_BITS-1 -: NUM_IN]; 0: first byte -> block[NUM_IN-1:0]
// PORTS
//  clk          in   1         clock, rising edge
//  n_rst        in   1         asynchronous, active-low reset
//  byte_in      in   NUM_IN    input byte
//  byte_valid   in   1         byte_in valid
//  byte_ready   out  1         block accepts a byte this cycle
//  block_out    out  NUM_BITS  assembled block, stable while block_valid=1
//  block_valid  out  1         block_out complete
//  block_ready  in   1         consumer takes block_out this cycle
//  byte_count   out  4         bytes held in the current partial block (0..NUM_BITS/NUM_IN-1)
// BEHAVIOUR
//  Reset:
//   - state=ACCUM, shift register=0, byte_count=0, block_valid=0.
//   - Reset mid-block discards all partial data.
//  FSM (registered, 2 states):
//   - ACCUM: byte_ready=1. On byte_valid&byte_ready, shift the byte in.
//     SHIFT_MSB=1: reg<={reg[NUM_BITS-NUM_IN-1:0],byte_in}. SHIFT_MSB=0: reg<={byte_in,reg[NUM_BITS-1:NUM_IN]}.
//     byte_count increments. On the accept of byte NUM_BITS/NUM_IN: byte_count wraps to 0 and state goes to FULL.
//   - FULL: block_valid=1, byte_ready=0, reg frozen. On block_ready: state goes to ACCUM.
//  Timing:
//   - block_valid rises the cycle after the 16th byte is accepted.
//   - The next byte is accepted no earlier than the cycle after the block handshake (no same-cycle overlap).
//  Outputs:
//   - block_out = reg, driven continuously; the consumer must sample only while block_valid=1.
//   - byte_ready and block_valid decode combinationally from registered state only.
//   - byte_count is registered.
//  Boundaries:
//   - byte_valid while FULL: ignored, byte not consumed.
//   - block_ready while ACCUM: ignored.
//   - byte_valid low mid-block: state holds indefinitely, no timeout.
// CONFIGURATION
//  STP8TO128_FLUSH_EN defined:
//   - Adds input `flush` (1 bit, synchronous).
//   - flush=1 forces reg=0, byte_count=0, state=ACCUM on the next edge, from any state; a held block is dropped.
//   - While flush=1, byte_ready=0, so no byte is consumed.
//   - flush takes priority over byte_valid and block_ready in the same cycle.
//  STP8TO128_FLUSH_EN undefined:
//   - No flush port. A partial block is only discarded by n_rst.
// STRUCTURE
//  Package stp_pkg:
//   - typedef enum logic {ACCUM, FULL} stp_state_t.
//   - localparam STP_NUM_BYTES = 16.
//   - localparam STP_CNT_W = 4.
//  Sub-module stp_byte_counter:
//   - 4-bit counter with enable and sync clear; outputs count and a terminal flag (count==STP_NUM_BYTES-1).
//  Top holds the FSM, the shift register and the output decode.
// TESTING
//  1. Reset then 16 back-to-back bytes 0x00..0x0F, block_ready=1 ->
//     block_valid one cycle after byte 16; block_out=128'h000102030405060708090A0B0C0D0E0F.
//  2. SHIFT_MSB=0, same stimulus -> block_out=128'h0F0E0D0C0B0A09080706050403020100.
//  3. Block complete with block_ready=0 for 10 cycles while byte_valid=1 with 0xAA ->
//     byte_ready=0 throughout, block_out unchanged, no 0xAA in next block.
//  4. 5 bytes 0xFF, assert n_rst for 1 cycle, then 16 bytes 0x11 -> block_out=all 0x11; byte_count was 0 after reset.
//  5. FLUSH_EN: 7 bytes, flush with byte_valid=1 (0x55) -> byte_count=0, 0x55 not consumed,
//     next 16 bytes form a clean block.
//  6. Random byte_valid/block_ready gaps over 200 blocks -> output matches a scoreboard, no byte lost or duplicated.

Source files
------------

// File: rtl/stp_pkg.sv
// Shared types and sizing for the 8-to-128 serial-to-parallel block assembler.
package stp_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } stp_state_t;

  localparam int unsigned STP_NUM_BYTES = 16;
  localparam int unsigned STP_CNT_W     = 4;

endpackage

// File: rtl/stp_byte_counter.sv
// Byte-position counter for the block assembler: enable, sync clear, wrap at LAST_VAL.
module stp_byte_counter
  import stp_pkg::*;
#(
  parameter int unsigned LAST_VAL = STP_NUM_BYTES - 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 en,
  input  logic                 clr,
  output logic [STP_CNT_W-1:0] count,
  output logic                 terminal_c
);

  logic [STP_CNT_W-1:0] count_q;
  logic [STP_CNT_W-1:0] count_d;

  assign terminal_c = (count_q == STP_CNT_W'(LAST_VAL));
  assign count      = count_q;

  // Clear wins over enable; the terminal accept wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (terminal_c) begin
        count_d = '0;
      end else begin
        count_d = count_q + STP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/stp8to128.sv
// Serial-to-parallel assembler: packs NUM_BITS/NUM_IN input bytes into one block.
// Optional synchronous flush input is enabled by defining STP8TO128_FLUSH_EN.
module stp8to128
  import stp_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 128,
  parameter int unsigned NUM_IN    = 8,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
`ifdef STP8TO128_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic [NUM_IN-1:0]    byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [NUM_BITS-1:0]  block_out,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic [STP_CNT_W-1:0] byte_count
);

  localparam int unsigned NUM_WORDS = NUM_BITS / NUM_IN;

  stp_state_t          state_q;
  stp_state_t          state_d;
  logic [NUM_BITS-1:0] shreg_q;
  logic [NUM_BITS-1:0] shreg_d;
  logic [NUM_BITS-1:0] shifted;
  logic                flush_c;
  logic                accept_c;
  logic                last_byte_c;

`ifdef STP8TO128_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // First byte ends up at the MSB end (SHIFT_MSB=1) or the LSB end (SHIFT_MSB=0).
  always_comb begin
    if (SHIFT_MSB) begin
      shifted = {shreg_q[NUM_BITS-NUM_IN-1:0], byte_in};
    end else begin
      shifted = {byte_in, shreg_q[NUM_BITS-1:NUM_IN]};
    end
  end

  assign accept_c = byte_valid && byte_ready;

  stp_byte_counter #(
    .LAST_VAL (NUM_WORDS - 1)
  ) u_cnt (
    .clk        (clk),
    .n_rst      (n_rst),
    .en         (accept_c),
    .clr        (flush_c),
    .count      (byte_count),
    .terminal_c (last_byte_c)
  );

  // Next state, shift register update and handshake decode.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_ready  = 1'b0;
    block_valid = 1'b0;

    unique case (state_q)
      ACCUM: begin
        byte_ready = !flush_c;
        if (accept_c) begin
          shreg_d = shifted;
          if (last_byte_c) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        block_valid = 1'b1;
        if (block_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    // Flush drops any partial or held block.
    if (flush_c) begin
      state_d = ACCUM;
      shreg_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ACCUM;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  assign block_out = shreg_q;

endmodule

// File: tb/tb_stp8to128.sv
// Self-checking bench for stp8to128: MSB- and LSB-first instances share stimulus,
// a negedge scoreboard tracks accepted bytes and compares every delivered block.
module tb_stp8to128;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         flush_i;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         block_ready;

  logic         rdy0, rdy1, bv0, bv1;
  logic [127:0] blk0, blk1;
  logic [3:0]   cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  logic [7:0]   part_q[$];
  logic [127:0] exp_msb_q[$];
  logic [127:0] exp_lsb_q[$];
  bit           m_full = 1'b0;
  int           n_blk = 0;

  always #5 clk = ~clk;

  stp8to128 #(.NUM_BITS(128), .NUM_IN(8), .SHIFT_MSB(1'b1)) dut_msb (
    .clk         (clk),
    .n_rst       (n_rst),
`ifdef STP8TO128_FLUSH_EN
    .flush       (flush_i),
`endif
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (rdy0),
    .block_out   (blk0),
    .block_valid (bv0),
    .block_ready (block_ready),
    .byte_count  (cnt0)
  );

  stp8to128 #(.NUM_BITS(128), .NUM_IN(8), .SHIFT_MSB(1'b0)) dut_lsb (
    .clk         (clk),
    .n_rst       (n_rst),
`ifdef STP8TO128_FLUSH_EN
    .flush       (flush_i),
`endif
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (rdy1),
    .block_out   (blk1),
    .block_valid (bv1),
    .block_ready (block_ready),
    .byte_count  (cnt1)
  );

  // Scoreboard: the model decides what each handshake should do, independent of DUT state.
  initial begin
    logic         exp_rdy;
    logic [127:0] em, el, pm, pl;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        part_q.delete();
        exp_msb_q.delete();
        exp_lsb_q.delete();
        m_full = 1'b0;
      end else begin
        exp_rdy = !m_full && !flush_i;
        checks++;
        if (rdy0 !== exp_rdy || rdy1 !== exp_rdy) begin
          errors++;
          $display("FAIL byte_ready t=%0t got %b/%b expected %b", $time, rdy0, rdy1, exp_rdy);
        end
        checks++;
        if (bv0 !== m_full || bv1 !== m_full) begin
          errors++;
          $display("FAIL block_valid t=%0t got %b/%b expected %b", $time, bv0, bv1, m_full);
        end
        checks++;
        if (cnt0 !== 4'(part_q.size()) || cnt1 !== 4'(part_q.size())) begin
          errors++;
          $display("FAIL byte_count t=%0t got %0d/%0d expected %0d", $time, cnt0, cnt1, part_q.size());
        end
        if (flush_i) begin
          part_q.delete();
          if (m_full && exp_msb_q.size() > 0) begin
            pm = exp_msb_q.pop_front();
            pl = exp_lsb_q.pop_front();
          end
          m_full = 1'b0;
        end else if (m_full) begin
          if (block_ready) begin
            checks++;
            if (exp_msb_q.size() == 0) begin
              errors++;
              $display("FAIL block_unexpected t=%0t got %h expected none", $time, blk0);
            end else begin
              em = exp_msb_q.pop_front();
              el = exp_lsb_q.pop_front();
              if (blk0 !== em || blk1 !== el) begin
                errors++;
                $display("FAIL block_data t=%0t got %h/%h expected %h/%h", $time, blk0, blk1, em, el);
              end
            end
            m_full = 1'b0;
            n_blk++;
          end
        end else if (byte_valid) begin
          part_q.push_back(byte_in);
          if (part_q.size() == 16) begin
            em = '0;
            el = '0;
            for (int i = 0; i < 16; i++) begin
              em[127-8*i -: 8] = part_q[i];
              el[8*i +: 8]     = part_q[i];
            end
            exp_msb_q.push_back(em);
            exp_lsb_q.push_back(el);
            part_q.delete();
            m_full = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      byte_in    = base + 8'(i);
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_rst       = 1'b0;
    flush_i     = 1'b0;
    byte_in     = '0;
    byte_valid  = 1'b0;
    block_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (bv0 !== 1'b0 || cnt0 !== 4'd0 || blk0 !== 128'd0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got bv=%b cnt=%0d blk=%h rdy=%b expected 0/0/0/1", bv0, cnt0, blk0, rdy0);
    end
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_packing();
    block_ready = 1'b1;
    send_block(8'h00);
    checks++;
    if (bv0 !== 1'b1 || blk0 !== 128'h000102030405060708090A0B0C0D0E0F) begin
      errors++;
      $display("FAIL msb_first got bv=%b blk=%h expected 1/000102030405060708090a0b0c0d0e0f", bv0, blk0);
    end
    checks++;
    if (bv1 !== 1'b1 || blk1 !== 128'h0F0E0D0C0B0A09080706050403020100) begin
      errors++;
      $display("FAIL lsb_first got bv=%b blk=%h expected 1/0f0e0d0c0b0a09080706050403020100", bv1, blk1);
    end
    tick();
    checks++;
    if (bv0 !== 1'b0) begin
      errors++;
      $display("FAIL block_release got bv=%b expected 0", bv0);
    end
  endtask

  task automatic test_hold();
    logic [127:0] held;
    held = '0;
    for (int i = 0; i < 16; i++) held[127-8*i -: 8] = 8'h20 + 8'(i);
    block_ready = 1'b0;
    send_block(8'h20);
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (rdy0 !== 1'b0 || bv0 !== 1'b1 || blk0 !== held) begin
        errors++;
        $display("FAIL hold_full c=%0d got rdy=%b bv=%b blk=%h expected 0/1/%h", c, rdy0, bv0, blk0, held);
      end
      tick();
    end
    byte_valid  = 1'b0;
    block_ready = 1'b1;
    tick();
    send_block(8'h30);
    tick();
  endtask

  task automatic test_reset_mid();
    block_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_in    = 8'hFF;
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    n_rst      = 1'b0;
    tick();
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_count got %0d/%0d expected 0", cnt0, cnt1);
    end
    n_rst = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      byte_in    = 8'h11;
      byte_valid = 1'b1;
      tick();
    end
    byte_valid = 1'b0;
    checks++;
    if (bv0 !== 1'b1 || blk0 !== {16{8'h11}}) begin
      errors++;
      $display("FAIL reset_mid_block got bv=%b blk=%h expected 1/%h", bv0, blk0, {16{8'h11}});
    end
    tick();
  endtask

`ifdef STP8TO128_FLUSH_EN
  task automatic test_flush();
    logic [127:0] exp;
    exp = '0;
    for (int i = 0; i < 16; i++) exp[127-8*i -: 8] = 8'h60 + 8'(i);
    block_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      byte_in    = 8'h40 + 8'(i);
      byte_valid = 1'b1;
      tick();
    end
    byte_in = 8'h55;
    flush_i = 1'b1;
    checks++;
    if (rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready got %b expected 0", rdy0);
    end
    tick();
    flush_i    = 1'b0;
    byte_valid = 1'b0;
    checks++;
    if (cnt0 !== 4'd0 || blk0 !== 128'd0) begin
      errors++;
      $display("FAIL flush_clear got cnt=%0d blk=%h expected 0/0", cnt0, blk0);
    end
    send_block(8'h60);
    checks++;
    if (bv0 !== 1'b1 || blk0 !== exp) begin
      errors++;
      $display("FAIL flush_next_block got bv=%b blk=%h expected 1/%h", bv0, blk0, exp);
    end
    tick();
    block_ready = 1'b0;
    send_block(8'h70);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    checks++;
    if (bv0 !== 1'b0 || blk0 !== 128'd0) begin
      errors++;
      $display("FAIL flush_full got bv=%b blk=%h expected 0/0", bv0, blk0);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    int  start;
    int  cycles;
    bit  acc;
    start       = n_blk;
    cycles      = 0;
    byte_in     = 8'($urandom);
    byte_valid  = ($urandom_range(0, 9) < 7);
    block_ready = ($urandom_range(0, 9) < 6);
    while ((n_blk - start) < 200 && cycles < 40000) begin
      @(negedge clk);
      acc = byte_valid && rdy0;
      @(posedge clk);
      #1;
      if (acc) byte_in = 8'($urandom);
      byte_valid  = ($urandom_range(0, 9) < 7);
      block_ready = ($urandom_range(0, 9) < 6);
      cycles++;
    end
    checks++;
    if ((n_blk - start) < 200) begin
      errors++;
      $display("FAIL random_timeout got %0d blocks expected 200", n_blk - start);
    end
    byte_valid  = 1'b0;
    block_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (exp_msb_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d pending expected 0", exp_msb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_hold();
    test_reset_mid();
`ifdef STP8TO128_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
